// File: rtl/timer_param_ctrl.sv
// Countdown timer with four reprogrammable delay registers (seconds) and a
// free-running divider that produces the one-second tick.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start_timer
// LOAD    | one cycle: sample interval, load counter from delay register
// COUNT   | counting seconds down; seconds_left shows the counter
// EXPIRED | one cycle: expired pulse, then reload or return to IDLE
module timer_param_ctrl #(
    parameter int         CLKS_PER_SEC = 100000000,
    parameter logic [3:0] T_ARM        = 4'd6,
    parameter logic [3:0] T_DRIVER     = 4'd8,
    parameter logic [3:0] T_PASSENGER  = 4'd15,
    parameter logic [3:0] T_ALARM      = 4'd10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_timer,
    input  logic [1:0] interval,
    input  logic       reprogram,
    input  logic [1:0] time_param_sel,
    input  logic [3:0] time_value,
    output logic       one_hz_enable,
    output logic       expired,
    output logic [3:0] seconds_left,
    output logic [1:0] timer_state
);

    localparam int               DIV_W   = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        LOAD    = 2'b01,
        COUNT   = 2'b10,
        EXPIRED = 2'b11
    } state_t;

    state_t           state;
    logic [3:0]       counter;
    logic [DIV_W-1:0] divider;
    logic [3:0]       delay_reg [4];
    logic             tick;

    assign tick = (divider == DIV_MAX);

    // Outputs are plain decodes of registers, so reset clears them at once.
    assign one_hz_enable = tick;
    assign expired       = (state == EXPIRED);
    assign seconds_left  = (state == COUNT) ? counter : 4'd0;
    assign timer_state   = state;

    // Free-running second divider; restarted on the LOAD->COUNT edge so the
    // first counted second is a full period.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            divider <= '0;
        end else if (state == LOAD && !reprogram) begin
            divider <= '0;
        end else if (tick) begin
            divider <= '0;
        end else begin
            divider <= divider + DIV_W'(1);
        end
    end

    // Delay registers; new values are only picked up at the next LOAD.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            delay_reg[0] <= T_ARM;
            delay_reg[1] <= T_DRIVER;
            delay_reg[2] <= T_PASSENGER;
            delay_reg[3] <= T_ALARM;
        end else if (reprogram) begin
            delay_reg[time_param_sel] <= time_value;
        end
    end

    // Sequencing FSM and seconds counter; reprogram overrides every transition.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            counter <= 4'd0;
        end else if (reprogram) begin
            state   <= IDLE;
            counter <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_timer) state <= LOAD;
                end
                LOAD: begin
                    counter <= delay_reg[interval];
                    state   <= COUNT;
                end
                COUNT: begin
                    if (!start_timer) begin
                        state   <= IDLE;
                        counter <= 4'd0;
                    end else if (counter == 4'd0) begin
                        state <= EXPIRED;
                    end else if (tick) begin
                        counter <= counter - 4'd1;
                    end
                end
                EXPIRED: begin
                    state <= start_timer ? LOAD : IDLE;
                end
                default: begin
                    state   <= IDLE;
                    counter <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_param_ctrl.sv
// Directed bench for timer_param_ctrl with a 4-cycle second.
module tb_timer_param_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start_timer = 1'b0;
    logic [1:0] interval = 2'b00;
    logic       reprogram = 1'b0;
    logic [1:0] time_param_sel = 2'b00;
    logic [3:0] time_value = 4'd0;
    logic       one_hz_enable;
    logic       expired;
    logic [3:0] seconds_left;
    logic [1:0] timer_state;

    int errors = 0;
    int checks = 0;

    timer_param_ctrl #(.CLKS_PER_SEC(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .start_timer   (start_timer),
        .interval      (interval),
        .reprogram     (reprogram),
        .time_param_sel(time_param_sel),
        .time_value    (time_value),
        .one_hz_enable (one_hz_enable),
        .expired       (expired),
        .seconds_left  (seconds_left),
        .timer_state   (timer_state)
    );

    always #5 clock = ~clock;

    // Advance one rising edge and settle.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        start_timer = 1'b0;
        reprogram   = 1'b0;
        #2 reset = 1'b0;
        #3 reset = 1'b1;
        tick();
    endtask

    task automatic do_reprogram(input logic [1:0] sel, input logic [3:0] val);
        reprogram      = 1'b1;
        time_param_sel = sel;
        time_value     = val;
        tick();
        reprogram = 1'b0;
    endtask

    // Start from IDLE; n = edge index (first sampling edge = 0) after which
    // expired is high, or -1 on timeout. Returns to IDLE afterwards.
    task automatic run_start(input logic [1:0] iv, output int n);
        start_timer = 1'b1;
        interval    = iv;
        n = -1;
        for (int k = 0; k < 120; k++) begin
            tick();
            if (expired) begin
                n = k;
                break;
            end
        end
        start_timer = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({one_hz_enable, expired, seconds_left, timer_state} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got hz=%b exp=%b sl=%0d st=%b, want all 0",
                     one_hz_enable, expired, seconds_left, timer_state);
        end
        #2 reset = 1'b1;
        tick();
    endtask

    task automatic test_driver();
        int exp_cnt = 0;
        int exp_edge = -1;
        start_timer = 1'b1;
        interval    = 2'b01;
        tick();
        checks++;
        if (timer_state !== 2'b01) begin
            errors++;
            $display("FAIL driver_load_state: got %b, want 01", timer_state);
        end
        tick();
        checks++;
        if (timer_state !== 2'b10 || seconds_left !== 4'd8) begin
            errors++;
            $display("FAIL driver_count_start: got st=%b sl=%0d, want st=10 sl=8", timer_state, seconds_left);
        end
        for (int k = 2; k <= 40; k++) begin
            tick();
            if (k == 4) begin
                checks++;
                if (one_hz_enable !== 1'b1) begin
                    errors++;
                    $display("FAIL hz_tick_edge4: got %b, want 1", one_hz_enable);
                end
            end
            if (k == 5) begin
                checks++;
                if (one_hz_enable !== 1'b0 || seconds_left !== 4'd7) begin
                    errors++;
                    $display("FAIL driver_after_tick: got hz=%b sl=%0d, want hz=0 sl=7", one_hz_enable, seconds_left);
                end
            end
            if (expired) begin
                exp_cnt++;
                exp_edge = k;
                start_timer = 1'b0;
            end
        end
        checks++;
        if (exp_cnt != 1 || exp_edge != 34) begin
            errors++;
            $display("FAIL driver_expired: got count=%0d edge=%0d, want count=1 edge=34", exp_cnt, exp_edge);
        end
        checks++;
        if (timer_state !== 2'b00) begin
            errors++;
            $display("FAIL driver_back_idle: got %b, want 00", timer_state);
        end
    endtask

    task automatic test_reprogram();
        int n;
        logic [3:0] want [3];
        want[0] = 4'd6;
        want[1] = 4'd8;
        want[2] = 4'd15;
        do_reprogram(2'b11, 4'd3);
        run_start(2'b11, n);
        checks++;
        if (n != 14) begin
            errors++;
            $display("FAIL reprog_alarm3: got expired at edge %0d, want 14", n);
        end
        for (int i = 0; i < 3; i++) begin
            start_timer = 1'b1;
            interval    = 2'(i);
            tick();
            tick();
            checks++;
            if (seconds_left !== want[i]) begin
                errors++;
                $display("FAIL default_reg_%0d: got %0d, want %0d", i, seconds_left, want[i]);
            end
            start_timer = 1'b0;
            repeat (3) tick();
        end
    endtask

    task automatic test_zero();
        int n;
        do_reprogram(2'b00, 4'd0);
        run_start(2'b00, n);
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL zero_delay: got expired at edge %0d, want 2", n);
        end
    endtask

    task automatic test_abort();
        int k5 = -1;
        int exp_cnt = 0;
        apply_reset();
        start_timer = 1'b1;
        interval    = 2'b01;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (expired) exp_cnt++;
            if (timer_state == 2'b10 && seconds_left == 4'd5) begin
                k5 = k;
                break;
            end
        end
        checks++;
        if (k5 != 13) begin
            errors++;
            $display("FAIL abort_reach5: got edge %0d, want 13", k5);
        end
        start_timer = 1'b0;
        tick();
        checks++;
        if (timer_state !== 2'b00 || seconds_left !== 4'd0 || expired !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: got st=%b sl=%0d exp=%b, want 00/0/0", timer_state, seconds_left, expired);
        end
        repeat (40) begin
            tick();
            if (expired) exp_cnt++;
        end
        checks++;
        if (exp_cnt != 0) begin
            errors++;
            $display("FAIL abort_no_expired: got %0d pulses, want 0", exp_cnt);
        end
    endtask

    task automatic test_chained();
        int first = -1;
        int second = -1;
        apply_reset();
        start_timer = 1'b1;
        interval    = 2'b10;
        tick();
        tick();
        checks++;
        if (seconds_left !== 4'd15) begin
            errors++;
            $display("FAIL chain_passenger_load: got %0d, want 15", seconds_left);
        end
        interval = 2'b11;
        for (int k = 2; k < 200; k++) begin
            tick();
            if (expired) begin
                if (first < 0) first = k;
                else begin
                    second = k;
                    break;
                end
            end
        end
        start_timer = 1'b0;
        repeat (3) tick();
        checks++;
        if (first != 62) begin
            errors++;
            $display("FAIL chain_first: got edge %0d, want 62", first);
        end
        checks++;
        if (second - first != 43) begin
            errors++;
            $display("FAIL chain_gap: got %0d, want 43", second - first);
        end
    endtask

    task automatic test_async_reset();
        int exp_cnt = 0;
        apply_reset();
        start_timer = 1'b1;
        interval    = 2'b01;
        repeat (8) tick();
        checks++;
        if (seconds_left !== 4'd7) begin
            errors++;
            $display("FAIL async_pre: got %0d, want 7", seconds_left);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({one_hz_enable, expired, seconds_left, timer_state} !== 8'h00) begin
            errors++;
            $display("FAIL async_reset_outputs: got hz=%b exp=%b sl=%0d st=%b, want all 0",
                     one_hz_enable, expired, seconds_left, timer_state);
        end
        start_timer = 1'b0;
        tick();
        reset = 1'b1;
        repeat (40) begin
            tick();
            if (expired) exp_cnt++;
        end
        checks++;
        if (exp_cnt != 0) begin
            errors++;
            $display("FAIL async_no_expired: got %0d pulses, want 0", exp_cnt);
        end
    endtask

    task automatic test_reprogram_mid();
        int exp_cnt = 0;
        apply_reset();
        start_timer = 1'b1;
        interval    = 2'b01;
        repeat (8) tick();
        do_reprogram(2'b01, 4'd8);
        checks++;
        if (timer_state !== 2'b00 || seconds_left !== 4'd0 || expired !== 1'b0) begin
            errors++;
            $display("FAIL reprog_mid_idle: got st=%b sl=%0d exp=%b, want 00/0/0", timer_state, seconds_left, expired);
        end
        start_timer = 1'b0;
        repeat (40) begin
            tick();
            if (expired) exp_cnt++;
        end
        checks++;
        if (exp_cnt != 0) begin
            errors++;
            $display("FAIL reprog_mid_no_expired: got %0d pulses, want 0", exp_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_driver();
        test_reprogram();
        test_zero();
        test_abort();
        test_chained();
        test_async_reset();
        test_reprogram_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
